// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with credit-limited prefetch FIFO and IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_out_o,
    output logic        valid_o
);
    localparam int CW  = $clog2(2*FIFO_DEPTH+1);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int QAW = $clog2(2*FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    fifo_pc_q  [FIFO_DEPTH];
    logic [31:0]    fifo_ins_q [FIFO_DEPTH];
    logic [31:0]    pcq_q      [2*FIFO_DEPTH];
    logic [FAW-1:0] fifo_wp_q, fifo_rp_q;
    logic [QAW-1:0] pcq_wp_q, pcq_rp_q;
    logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d, live_q, live_d, drop_q, drop_d;
    logic [31:0]    instr_q, pc_q;
    logic           valid_q, gnt, dropping, push, pop;

    // Credit covers both buffered words and live requests so a response always has a slot.
    assign imem_req_o    = rst_ni && !redirect_i && (fifo_cnt_q + live_q < DEPTH);
    assign imem_addr_o   = fetch_pc_q;
    assign gnt           = imem_req_o && imem_gnt_i;
    assign dropping      = drop_q != '0;
    assign push          = imem_rvalid_i && !dropping && !redirect_i;
    assign pop           = !stall_i && !redirect_i && fifo_cnt_q != '0;
    assign instruction_o = instr_q;
    assign pc_out_o      = pc_q;
    assign valid_o       = valid_q;

    always_comb begin
        fetch_pc_d = redirect_i ? (redirect_pc_i & ~32'd3) : gnt ? fetch_pc_q + 32'd4 : fetch_pc_q;
        live_d     = redirect_i ? '0 : live_q + CW'(gnt) - CW'(imem_rvalid_i && !dropping);
        drop_d     = redirect_i ? drop_q + live_q - CW'(imem_rvalid_i) : drop_q - CW'(imem_rvalid_i && dropping);
        fifo_cnt_d = redirect_i ? '0 : fifo_cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_PC;
            fifo_wp_q  <= '0;
            fifo_rp_q  <= '0;
            fifo_cnt_q <= '0;
            pcq_wp_q   <= '0;
            pcq_rp_q   <= '0;
            live_q     <= '0;
            drop_q     <= '0;
            instr_q    <= NOP;
            pc_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fifo_cnt_q <= fifo_cnt_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
            pcq_wp_q   <= pcq_wp_q + QAW'(gnt);
            pcq_rp_q   <= pcq_rp_q + QAW'(imem_rvalid_i);
            fifo_wp_q  <= redirect_i ? '0 : fifo_wp_q + FAW'(push);
            fifo_rp_q  <= redirect_i ? '0 : fifo_rp_q + FAW'(pop);
            if (redirect_i || !stall_i) begin
                valid_q <= pop;
                instr_q <= pop ? fifo_ins_q[fifo_rp_q] : NOP;
                pc_q    <= pop ? fifo_pc_q[fifo_rp_q] : pc_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt) pcq_q[pcq_wp_q] <= fetch_pc_q;
        if (push) begin
            fifo_pc_q[fifo_wp_q]  <= pcq_q[pcq_rp_q];
            fifo_ins_q[fifo_wp_q] <= imem_rdata_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_cnt_q == DEPTH));
    a_pending_cap: assert property (@(posedge clk_i) disable iff (!rst_ni) (live_q + drop_q) <= CW'(2*FIFO_DEPTH));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: memory model plus in-order scoreboard of expected IF/ID entries, with directed scenarios.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk_i = 1'b0, rst_ni = 1'b0, stall_i = 1'b0, redirect_i = 1'b0;
    logic        imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0, imem_rdata_i = '0;
    logic        imem_req_o, valid_o;
    logic [31:0] imem_addr_o, instruction_o, pc_out_o;
    int          errs = 0, checks = 0, cyc = 0, lat = 1, last_due = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] next_addr = '0;
    typedef struct { int due; logic [31:0] addr; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
    mreq_t mq[$];
    exp_t  sb[$];
    exp_t  e;
    mreq_t m;

    fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instruction_o(instruction_o), .pc_out_o(pc_out_o), .valid_o(valid_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Mid-cycle: score the IF/ID entry, track grants, and drive this cycle's response.
    always @(negedge clk_i) begin
        cyc++;
        if (!rst_ni) begin
            mq.delete();
            sb.delete();
            imem_rvalid_i = 1'b0;
            prev_stall = 1'b0;
            last_due = 0;
        end else begin
            if (valid_o && !prev_stall) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_pc", pc_out_o, e.pc);
                    check("sb_ins", instruction_o, e.ins);
                end
            end
            if (!valid_o) check("idle_nop", instruction_o, NOP);
            if (redirect_i) sb.delete();
            if (imem_req_o && imem_gnt_i) begin
                last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                mq.push_back('{last_due, imem_addr_o});
                sb.push_back('{imem_addr_o, mem_word(imem_addr_o)});
                next_addr = imem_addr_o + 32'd4;
            end
            imem_rvalid_i = 1'b0;
            if (mq.size() != 0) begin
                if (mq[0].due == cyc) begin
                    m = mq.pop_front();
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i = mem_word(m.addr);
                end
            end
            prev_stall = stall_i;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!valid_o && n < 40) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 32'(valid_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] a0;
        logic r0;
        imem_gnt_i = 1'b1;
        step(2);
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ins", instruction_o, NOP);
        check("rst_pc", pc_out_o, 32'd0);
        rst_ni = 1'b1;
        #1;
        check("first_req", 32'(imem_req_o), 32'd1);
        check("first_addr", imem_addr_o, 32'h0);
        step();
        check("addr1", imem_addr_o, 32'h4);
        step();
        check("addr2", imem_addr_o, 32'h8);
        check("valid_early", 32'(valid_o), 32'd0);
        step();
        check("valid_rise", 32'(valid_o), 32'd1);
        check("pc0", pc_out_o, 32'h0);
        step();
        check("pc1", pc_out_o, 32'h4);
        n = 0;
        while (pc_out_o != 32'h10 && n < 20) begin
            step();
            n++;
        end
        check("reach_10", pc_out_o, 32'h10);
        stall_i = 1'b1;
        repeat (10) begin
            step();
            check("stall_hold", pc_out_o, 32'h10);
        end
        check("stall_req", 32'(imem_req_o), 32'd0);
        check("stall_addr", imem_addr_o, 32'h24);
        stall_i = 1'b0;
        step();
        check("resume0", pc_out_o, 32'h14);
        step();
        check("resume1", pc_out_o, 32'h18);
        lat = 3;
        n = 0;
        while (mq.size() < 3 && n < 40) begin
            step();
            n++;
        end
        check("inflight3", 32'(mq.size()), 32'd3);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        #1;
        check("redir_noreq", 32'(imem_req_o), 32'd0);
        step();
        redirect_i = 1'b0;
        #1;
        check("redir_valid0", 32'(valid_o), 32'd0);
        check("redir_addr", imem_addr_o, 32'h100);
        check("redir_req", 32'(imem_req_o), 32'd1);
        wait_valid("redir", n);
        check("redir_lat", 32'(n + 1 >= 6), 32'd1);
        check("redir_pc", pc_out_o, 32'h100);
        check("redir_ins", instruction_o, mem_word(32'h100));
        step(3);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h203;
        stall_i = 1'b1;
        step();
        redirect_i = 1'b0;
        #1;
        check("rs_valid", 32'(valid_o), 32'd0);
        check("rs_addr", imem_addr_o, 32'h200);
        stall_i = 1'b0;
        wait_valid("rs", n);
        check("rs_pc", pc_out_o, 32'h200);
        lat = 1;
        step(4);
        imem_gnt_i = 1'b0;
        step(4);
        a0 = imem_addr_o;
        r0 = imem_req_o;
        check("gl_req", 32'(r0), 32'd1);
        check("gl_addr", a0, next_addr);
        repeat (5) begin
            step();
            check("gl_addr_stable", imem_addr_o, a0);
            check("gl_req_stable", 32'(imem_req_o), 32'(r0));
        end
        check("gl_drain_valid", 32'(valid_o), 32'd0);
        check("gl_drain_nop", instruction_o, NOP);
        imem_gnt_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        #1;
        check("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
        step();
        check("wrap_addr1", imem_addr_o, 32'h0);
        wait_valid("wrap", n);
        check("wrap_pc0", pc_out_o, 32'hFFFF_FFFC);
        step();
        check("wrap_pc1", pc_out_o, 32'h0);
        step(3);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_req", 32'(imem_req_o), 32'd0);
        check("mid_rst_nop", instruction_o, NOP);
        step(2);
        rst_ni = 1'b1;
        #1;
        check("post_rst_addr", imem_addr_o, 32'h0);
        check("post_rst_req", 32'(imem_req_o), 32'd1);
        step(8);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I pipeline, directly upstream of the decode stage. It owns the program counter, issues in-order word requests to instruction memory over a request/grant/response handshake, and buffers returned words with their PCs in a small prefetch FIFO. It drives the IF/ID pipeline register (instruction, PC, valid) consumed by decode. It honours a stall from the hazard logic and a redirect from EX on taken branches, JAL and JALR.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, ≥2); also the cap on live in-flight requests plus buffered words
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  1  hold the IF/ID register and FIFO head
- redirect  in  1  taken branch/jump from EX; discard all younger fetches
- redirect_pc  in  32  new fetch target; bits [1:0] forced to 00
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word address of request (= fetch_pc)
- imem_gnt  in  1  request accepted this cycle (imem_req && imem_gnt)
- imem_rvalid  in  1  response valid; responses return in request order, latency ≥1 cycle after grant
- imem_rdata  in  32  response instruction word
- instruction  out  32  IF/ID instruction to decode
- pc_out  out  32  IF/ID PC of instruction
- valid  out  1  IF/ID entry holds a real instruction

## Operation
- State: fetch_pc; FIFO of {pc, instr}; pc queue of granted-but-unreturned addresses (depth 2*FIFO_DEPTH); live_cnt (live in-flight requests); drop_cnt (stale in-flight requests to discard).
- imem_req = (fifo_count + live_cnt < FIFO_DEPTH) && !redirect; forced 0 while rst low. imem_addr = fetch_pc.
- On grant: push fetch_pc to pc queue, fetch_pc += 4 (wraps mod 2^32), live_cnt += 1.
- On imem_rvalid: pop pc queue. If drop_cnt > 0: drop_cnt -= 1, word discarded. Else: live_cnt -= 1, push {pc, imem_rdata} to FIFO. Push into a full FIFO cannot occur (credit rule); an assertion checks it.
- IF/ID update when !stall: FIFO non-empty → load head, valid=1, pop; empty → valid=0, instruction=32'h0000_0013 (NOP), pc_out unchanged.
- stall=1 and no redirect: IF/ID and FIFO head hold; fetching continues until credit is exhausted.
- Redirect (priority over stall): fetch_pc ← {redirect_pc[31:2],2'b00}; FIFO flushed; IF/ID ← valid=0, NOP; drop_cnt ← drop_cnt + live_cnt (rvalid arriving in the redirect cycle is discarded and counted out of that sum); live_cnt ← 0; no request issued in the redirect cycle; fetching resumes next cycle.
- Simultaneous push and pop on the FIFO: both take effect; count unchanged.
- Counters sized clog2(2*FIFO_DEPTH+1); live_cnt + drop_cnt ≤ 2*FIFO_DEPTH always.

## Timing
- Reset values: fetch_pc=RESET_PC, FIFO empty, live_cnt=drop_cnt=0, valid=0, instruction=32'h0000_0013, pc_out=0, imem_req=0.
- Reset asserted mid-operation clears all state immediately; in-flight responses after reset release are illegal (memory is reset together).
- First request in the first cycle after rst rises.
- Latency: grant in cycle t, rvalid in t+L → FIFO write at end of t+L → visible on IF/ID in cycle t+L+2 (no bypass).
- Throughput: one instruction/cycle sustained when FIFO_DEPTH ≥ L+2 and imem_gnt held high.
- Redirect in cycle t: first new request in t+1; first redirected instruction valid no earlier than t+L+3.
- Long stall: imem_req drops once fifo_count + live_cnt = FIFO_DEPTH.

## Test plan
- Reset then free run, L=1, gnt=1: addresses 0,4,8,… issued back-to-back; valid rises 3 cycles after the first request; pc_out 0,4,8,… on consecutive cycles.
- stall held 10 cycles mid-stream with pc_out=0x10: IF/ID stays 0x10; exactly 4 requests outstanding/buffered, then imem_req=0; release resumes 0x14, 0x18 with no gaps or duplicates.
- redirect to 0x100 with 3 requests in flight (L=3): 3 stale responses dropped; next valid pc_out=0x100 with its memory word; no stale PC ever appears.
- redirect_pc=0x203 asserted together with stall=1: fetch from 0x200; valid=0 next cycle despite stall.
- imem_gnt low for 5 cycles: imem_addr and imem_req stable; no fetch_pc advance; valid drains to 0 with NOP output.
- Wrap: redirect to 0xFFFF_FFFC: next fetch address 0x0000_0000; pc_out sequence 0xFFFF_FFFC, 0x0.
